// File: rtl/mux6_b16.sv
// Six-input, 16-bit datapath source selector with a loadable registered copy
// and an optional sticky illegal-select flag (enabled by MUX6B16_SEL_CHECK_EN).
module mux6_b16 (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic [15:0] C,
    input  logic [15:0] D,
    input  logic [15:0] E,
    input  logic [15:0] F,
    input  logic [2:0]  Selector,
    input  logic        load,
    input  logic        err_clr,
    output logic [15:0] result,
    output logic [15:0] result_q,
    output logic        sel_err,
    output logic        sel_err_q
);

    logic [15:0] result_d;

    // Codes 6 and 7 have no source and deliberately select zero.
    always_comb begin
        result = 16'h0000;
        case (Selector)
            3'd0:    result = A;
            3'd1:    result = B;
            3'd2:    result = C;
            3'd3:    result = D;
            3'd4:    result = E;
            3'd5:    result = F;
            default: result = 16'h0000;
        endcase
    end

    assign result_d = load ? result : result_q;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            result_q <= 16'h0000;
        end else begin
            result_q <= result_d;
        end
    end

`ifdef MUX6B16_SEL_CHECK_EN
    logic sel_err_d;

    assign sel_err = (Selector >= 3'd6);

    // Clear takes priority so software can acknowledge even while still illegal.
    always_comb begin
        sel_err_d = sel_err_q;
        if (err_clr) begin
            sel_err_d = 1'b0;
        end else if (sel_err) begin
            sel_err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end
`else
    logic unusedErrClr;

    assign unusedErrClr = err_clr;
    assign sel_err      = 1'b0;
    assign sel_err_q    = 1'b0;
`endif

endmodule

// File: tb/tb_mux6_b16.sv
// Directed self-checking bench for mux6_b16; expectations for the error flags
// follow whether MUX6B16_SEL_CHECK_EN is defined for this build.
module tb_mux6_b16;

    logic        CLK;
    logic        Reset_n;
    logic [15:0] A, B, C, D, E, F;
    logic [2:0]  Selector;
    logic        load;
    logic        err_clr;
    logic [15:0] result;
    logic [15:0] result_q;
    logic        sel_err;
    logic        sel_err_q;

    int errors = 0;
    int checks = 0;

`ifdef MUX6B16_SEL_CHECK_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    mux6_b16 dut (
        .CLK      (CLK),
        .Reset_n  (Reset_n),
        .A        (A),
        .B        (B),
        .C        (C),
        .D        (D),
        .E        (E),
        .F        (F),
        .Selector (Selector),
        .load     (load),
        .err_clr  (err_clr),
        .result   (result),
        .result_q (result_q),
        .sel_err  (sel_err),
        .sel_err_q(sel_err_q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic test_reset();
        Reset_n = 1'b0; load = 1'b1; err_clr = 1'b0; Selector = 3'd1;
        A = 16'd2000; B = 16'd55; C = 16'd78; D = 16'd33; E = 16'd4; F = 16'd999;
        #1;
        checks++;
        if (result_q !== 16'h0000) begin errors++; $display("[TB] FAIL reset_result_q got=%0d exp=0", result_q); end
        checks++;
        if (sel_err_q !== 1'b0) begin errors++; $display("[TB] FAIL reset_sel_err_q got=%b exp=0", sel_err_q); end
        checks++;
        if (result !== 16'd55) begin errors++; $display("[TB] FAIL reset_comb_live got=%0d exp=55", result); end
        @(posedge CLK); #1;
        checks++;
        if (result_q !== 16'h0000) begin errors++; $display("[TB] FAIL reset_hold_over_edge got=%0d exp=0", result_q); end
        @(negedge CLK);
        load = 1'b0;
        Reset_n = 1'b1;
    endtask

    task automatic test_select();
        logic [15:0] expVals [6] = '{16'd2000, 16'd55, 16'd78, 16'd33, 16'd4, 16'd999};
        for (int i = 0; i < 6; i++) begin
            Selector = 3'(i);
            #1;
            checks++;
            if (result !== expVals[i]) begin errors++; $display("[TB] FAIL select_%0d got=%0d exp=%0d", i, result, expVals[i]); end
            checks++;
            if (sel_err !== 1'b0) begin errors++; $display("[TB] FAIL select_err_%0d got=%b exp=0", i, sel_err); end
        end
    endtask

    task automatic test_comb_follow();
        Selector = 3'd5;
        #1;
        F = 16'd22222;
        #0;
        checks++;
        if (result !== 16'd22222) begin errors++; $display("[TB] FAIL follow_selected got=%0d exp=22222", result); end
        A = 16'd1234;
        #1;
        checks++;
        if (result !== 16'd22222) begin errors++; $display("[TB] FAIL ignore_unselected got=%0d exp=22222", result); end
    endtask

    task automatic test_illegal();
        @(negedge CLK);
        Selector = 3'd6;
        #1;
        checks++;
        if (result !== 16'h0000) begin errors++; $display("[TB] FAIL illegal6_result got=%0d exp=0", result); end
        checks++;
        if (sel_err !== ERR_ON) begin errors++; $display("[TB] FAIL illegal6_sel_err got=%b exp=%b", sel_err, ERR_ON); end
        Selector = 3'd7;
        #1;
        checks++;
        if (result !== 16'h0000) begin errors++; $display("[TB] FAIL illegal7_result got=%0d exp=0", result); end
        checks++;
        if (sel_err !== ERR_ON) begin errors++; $display("[TB] FAIL illegal7_sel_err got=%b exp=%b", sel_err, ERR_ON); end
        checks++;
        if (sel_err_q !== 1'b0) begin errors++; $display("[TB] FAIL sticky_before_edge got=%b exp=0", sel_err_q); end
        @(posedge CLK); #1;
        checks++;
        if (sel_err_q !== ERR_ON) begin errors++; $display("[TB] FAIL sticky_set got=%b exp=%b", sel_err_q, ERR_ON); end
        @(negedge CLK);
        Selector = 3'd0;
        @(posedge CLK); #1;
        checks++;
        if (sel_err_q !== ERR_ON) begin errors++; $display("[TB] FAIL sticky_hold got=%b exp=%b", sel_err_q, ERR_ON); end
        @(negedge CLK);
        err_clr = 1'b1;
        #1;
        checks++;
        if (sel_err_q !== ERR_ON) begin errors++; $display("[TB] FAIL clear_is_sync got=%b exp=%b", sel_err_q, ERR_ON); end
        @(posedge CLK); #1;
        checks++;
        if (sel_err_q !== 1'b0) begin errors++; $display("[TB] FAIL sticky_clear got=%b exp=0", sel_err_q); end
        @(negedge CLK);
        Selector = 3'd7;
        @(posedge CLK); #1;
        checks++;
        if (sel_err_q !== 1'b0) begin errors++; $display("[TB] FAIL clear_priority got=%b exp=0", sel_err_q); end
        @(negedge CLK);
        err_clr = 1'b0;
        Selector = 3'd0;
    endtask

    task automatic test_load();
        @(negedge CLK);
        Selector = 3'd1;
        load = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (result_q !== 16'd55) begin errors++; $display("[TB] FAIL load_capture got=%0d exp=55", result_q); end
        @(negedge CLK);
        load = 1'b0;
        Selector = 3'd2;
        @(posedge CLK); #1;
        checks++;
        if (result_q !== 16'd55) begin errors++; $display("[TB] FAIL load_hold got=%0d exp=55", result_q); end
    endtask

    task automatic test_async_reset();
        @(negedge CLK);
        Selector = 3'd6;
        @(negedge CLK);
        Selector = 3'd1;
        @(posedge CLK); #1;
        checks++;
        if (sel_err_q !== ERR_ON) begin errors++; $display("[TB] FAIL pre_reset_sticky got=%b exp=%b", sel_err_q, ERR_ON); end
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if (result_q !== 16'h0000) begin errors++; $display("[TB] FAIL async_reset_result_q got=%0d exp=0", result_q); end
        checks++;
        if (sel_err_q !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_sel_err_q got=%b exp=0", sel_err_q); end
        @(negedge CLK);
        Reset_n = 1'b1;
        Selector = 3'd3;
        load = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (result_q !== 16'd33) begin errors++; $display("[TB] FAIL recapture_after_reset got=%0d exp=33", result_q); end
        @(negedge CLK);
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_select();
        test_comb_follow();
        test_illegal();
        test_load();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
